// File: rtl/usb_rx_bit_timer.sv
// USB receive bit timer: recovers bit timing from the bus edge strobe,
// classifies NRZI bits, removes stuffed bits and issues shift/word strobes.
module usb_rx_bit_timer #(
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter int unsigned SAMPLE_POINT = 3,
    parameter int unsigned WORD_BITS    = 8,
    parameter int unsigned STUFF_LEN    = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic d_edge,
    input  logic receiving,
    output logic shift_enable,
    output logic byte_received,
    output logic stuff_skip,
    output logic stuff_error
);

    localparam int unsigned PHASE_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ONES_W  = (STUFF_LEN > 0) ? $clog2(STUFF_LEN + 1) : 1;
    localparam int unsigned CNT_W   = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

    logic [PHASE_W-1:0] phase, phase_n;
    logic               edge_seen, edge_seen_n;
    logic [ONES_W-1:0]  ones_run, ones_run_n;
    logic [CNT_W-1:0]   bit_cnt, bit_cnt_n;
    logic               shift_n, byte_n, skip_n, err_n;
    logic               sample;
    logic               bit_val;

    // Next-state and strobe decode for one bit period
    always_comb begin
        phase_n     = phase;
        edge_seen_n = edge_seen;
        ones_run_n  = ones_run;
        bit_cnt_n   = bit_cnt;
        shift_n     = 1'b0;
        byte_n      = 1'b0;
        skip_n      = 1'b0;
        err_n       = 1'b0;
        sample      = 1'b0;
        bit_val     = 1'b0;

        if (!receiving) begin
            // Idle bus: drop any partial timing or word progress
            phase_n     = '0;
            edge_seen_n = 1'b0;
            ones_run_n  = '0;
            bit_cnt_n   = '0;
        end else begin
            // An edge in the sample cycle wins: it is a resync, not a sample
            sample = (phase == PHASE_W'(SAMPLE_POINT)) && !d_edge;

            // The edge cycle counts as phase 0, so the following cycle is phase 1
            if (d_edge) begin
                phase_n = PHASE_W'(1);
            end else if (phase == PHASE_W'(CLKS_PER_BIT - 1)) begin
                phase_n = '0;
            end else begin
                phase_n = phase + PHASE_W'(1);
            end

            if (d_edge) begin
                edge_seen_n = 1'b1;
            end else if (sample) begin
                edge_seen_n = 1'b0;
            end

            if (sample) begin
                // NRZI: a transition in the bit period encodes 0
                bit_val = !edge_seen;
                if (ones_run == ONES_W'(STUFF_LEN)) begin
                    ones_run_n = '0;
                    if (bit_val) begin
                        err_n = 1'b1;
                    end else begin
                        skip_n = 1'b1;
                    end
                end else begin
                    shift_n    = 1'b1;
                    ones_run_n = bit_val ? (ones_run + ONES_W'(1)) : '0;
                    if (bit_cnt == CNT_W'(WORD_BITS - 1)) begin
                        byte_n    = 1'b1;
                        bit_cnt_n = '0;
                    end else begin
                        bit_cnt_n = bit_cnt + CNT_W'(1);
                    end
                end
            end
        end
    end

    // Timing state and registered strobes
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            phase         <= '0;
            edge_seen     <= 1'b0;
            ones_run      <= '0;
            bit_cnt       <= '0;
            shift_enable  <= 1'b0;
            byte_received <= 1'b0;
            stuff_skip    <= 1'b0;
            stuff_error   <= 1'b0;
        end else begin
            phase         <= phase_n;
            edge_seen     <= edge_seen_n;
            ones_run      <= ones_run_n;
            bit_cnt       <= bit_cnt_n;
            shift_enable  <= shift_n;
            byte_received <= byte_n;
            stuff_skip    <= skip_n;
            stuff_error   <= err_n;
        end
    end

endmodule
